// File: rtl/issue_scoreboard.sv
// +----------------------------------------------------------------------------+
// | issue_scoreboard: register busy-bit scoreboard, in-flight limit and HALT     |
// | drain sequencing. Optional macro: ISSUE_SCOREBOARD_BYPASS_EN.               |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module issue_scoreboard #(
  parameter int NUM_REGS     = 32,
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [5:0]          id_opcode,
  input  logic [4:0]          id_rs,
  input  logic [4:0]          id_rt,
  input  logic [4:0]          id_rd,
  output logic                id_ready,
  input  logic                wb_valid,
  input  logic [4:0]          wb_rd,
  output logic                issue_valid,
  output logic [4:0]          issue_rd,
  output logic                issue_wen,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [CNT_W-1:0]    inflight,
  output logic                halted,
  output logic                sb_error
);

  localparam logic [5:0]       C_OP_R    = 6'b000000;
  localparam logic [5:0]       C_OP_J    = 6'b000010;
  localparam logic [5:0]       C_OP_HALT = 6'b111111;
  localparam logic [CNT_W-1:0] C_MAX_INF = CNT_W'(MAX_INFLIGHT);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]    inflight_q, inflight_d;
  logic                issue_valid_q, issue_valid_d;
  logic [4:0]          issue_rd_q, issue_rd_d;
  logic                issue_wen_q, issue_wen_d;
  logic                sb_error_q, sb_error_d;

  logic                is_r, is_j, is_halt, reads_rs, reads_rt, wen, hazard, fire;
  logic [4:0]          dest;
  logic                wb_hit, wb_spurious;
  logic [NUM_REGS-1:0] wb_clr, haz_busy;
  logic [CNT_W-1:0]    haz_inflight;

  // Decode and writeback qualification
  always_comb begin
    is_r     = (id_opcode == C_OP_R);
    is_j     = (id_opcode == C_OP_J);
    is_halt  = (id_opcode == C_OP_HALT);
    reads_rs = ~is_j & ~is_halt;
    reads_rt = is_r;
    if (is_r)
      dest = id_rd;
    else if (is_j || is_halt)
      dest = 5'd0;
    else
      dest = id_rt;
    wen = (dest != 5'd0);

    wb_hit      = wb_valid && (wb_rd != 5'd0) && busy_q[wb_rd];
    wb_spurious = wb_valid && (wb_rd != 5'd0) && !busy_q[wb_rd];
    wb_clr      = '0;
    if (wb_hit)
      wb_clr[wb_rd] = 1'b1;
  end

  // Hazard view: with bypass, a retiring writeback already counts as free
  always_comb begin
`ifdef ISSUE_SCOREBOARD_BYPASS_EN
    haz_busy     = busy_q & ~wb_clr;
    haz_inflight = inflight_q - CNT_W'(wb_hit);
`else
    haz_busy     = busy_q;
    haz_inflight = inflight_q;
`endif
    hazard = (reads_rs && haz_busy[id_rs]) ||
             (reads_rt && haz_busy[id_rt]) ||
             (wen && haz_busy[dest]) ||
             (wen && (haz_inflight == C_MAX_INF));
    id_ready = (state_q == ST_RUN) && !hazard;
    fire     = id_valid && id_ready;
  end

  always_comb begin
    busy_d = busy_q & ~wb_clr;
    // Set after clear so a same-register set/clear leaves the bit busy
    if (fire && wen)
      busy_d[dest] = 1'b1;
    inflight_d    = inflight_q + CNT_W'(fire && wen) - CNT_W'(wb_hit);
    issue_valid_d = fire;
    issue_rd_d    = (fire && wen) ? dest : 5'd0;
    issue_wen_d   = fire && wen;
    sb_error_d    = sb_error_q || wb_spurious;

    state_d = state_q;
    case (state_q)
      ST_RUN:
        if (fire && is_halt)
          state_d = ST_DRAIN;
      ST_DRAIN:
        if ((inflight_q == '0) || ((inflight_q == CNT_W'(1)) && wb_hit))
          state_d = ST_HALTED;
      ST_HALTED:
        state_d = ST_HALTED;
      default:
        state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      busy_q        <= '0;
      inflight_q    <= '0;
      issue_valid_q <= 1'b0;
      issue_rd_q    <= 5'd0;
      issue_wen_q   <= 1'b0;
      sb_error_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      inflight_q    <= inflight_d;
      issue_valid_q <= issue_valid_d;
      issue_rd_q    <= issue_rd_d;
      issue_wen_q   <= issue_wen_d;
      sb_error_q    <= sb_error_d;
    end
  end

  assign issue_valid = issue_valid_q;
  assign issue_rd    = issue_rd_q;
  assign issue_wen   = issue_wen_q;
  assign busy_mask   = busy_q;
  assign inflight    = inflight_q;
  assign halted      = (state_q == ST_HALTED);
  assign sb_error    = sb_error_q;

endmodule

`default_nettype wire

// File: tb/tb_issue_scoreboard.sv
// +----------------------------------------------------------------------------+
// | tb_issue_scoreboard: directed vector table plus HALT/reset sequences.       |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_issue_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [5:0]  id_opcode;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_wen;
  logic [31:0] busy_mask;
  logic [2:0]  inflight;
  logic        halted;
  logic        sb_error;

  int total = 0;
  int bad   = 0;

  issue_scoreboard dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_ready(id_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_wen(issue_wen),
    .busy_mask(busy_mask), .inflight(inflight), .halted(halted), .sb_error(sb_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    logic        wbv;
    logic [4:0]  wbrd;
    logic        e_rdy;
    logic        e_iv;
    logic [4:0]  e_ird;
    logic        e_iwen;
    logic [31:0] e_busy;
    logic [2:0]  e_inf;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int v, int op, int rs, int rt, int rd, int wbv, int wbrd,
                              int rdy, int iv, int ird, int iwen, int busy, int inf, int err);
    vec_t t;
    t.v = 1'(v); t.op = 6'(op); t.rs = 5'(rs); t.rt = 5'(rt); t.rd = 5'(rd);
    t.wbv = 1'(wbv); t.wbrd = 5'(wbrd);
    t.e_rdy = 1'(rdy); t.e_iv = 1'(iv); t.e_ird = 5'(ird); t.e_iwen = 1'(iwen);
    t.e_busy = 32'(busy); t.e_inf = 3'(inf); t.e_err = 1'(err);
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int v, input int op, input int rs, input int rt, input int rd,
                       input int wbv, input int wbrd);
    id_valid = 1'(v); id_opcode = 6'(op); id_rs = 5'(rs); id_rt = 5'(rt); id_rd = 5'(rd);
    wb_valid = 1'(wbv); wb_rd = 5'(wbrd);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    drive(0, 2, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
  endtask

  localparam int OP_R = 0, OP_J = 2, OP_I = 8, OP_H = 63;

  initial begin
    rst = 1'b1;
    drive(0, OP_J, 0, 0, 0, 0, 0);
    // Scenario 1: RAW stall on r5
    vecs.push_back(mk(1, OP_R, 1, 2, 5, 0, 0, 1, 1, 5, 1, 'h20, 1, 0));
    vecs.push_back(mk(1, OP_I, 5, 6, 0, 0, 0, 0, 0, 0, 0, 'h20, 1, 0));
    vecs.push_back(mk(1, OP_I, 5, 6, 0, 0, 0, 0, 0, 0, 0, 'h20, 1, 0));
`ifdef ISSUE_SCOREBOARD_BYPASS_EN
    vecs.push_back(mk(1, OP_I, 5, 6, 0, 1, 5, 1, 1, 6, 1, 'h40, 1, 0));
    vecs.push_back(mk(0, OP_I, 5, 6, 0, 0, 0, 0, 0, 0, 0, 'h40, 1, 0));
`else
    vecs.push_back(mk(1, OP_I, 5, 6, 0, 1, 5, 0, 0, 0, 0, 'h00, 0, 0));
    vecs.push_back(mk(1, OP_I, 5, 6, 0, 0, 0, 1, 1, 6, 1, 'h40, 1, 0));
`endif
    vecs.push_back(mk(0, OP_J, 0, 0, 0, 1, 6, 1, 0, 0, 0, 'h00, 0, 0));
    // Scenario 2: in-flight limit
    vecs.push_back(mk(1, OP_I, 0, 1, 0, 0, 0, 1, 1, 1, 1, 'h02, 1, 0));
    vecs.push_back(mk(1, OP_I, 0, 2, 0, 0, 0, 1, 1, 2, 1, 'h06, 2, 0));
    vecs.push_back(mk(1, OP_I, 0, 3, 0, 0, 0, 1, 1, 3, 1, 'h0E, 3, 0));
    vecs.push_back(mk(1, OP_I, 0, 4, 0, 0, 0, 1, 1, 4, 1, 'h1E, 4, 0));
    vecs.push_back(mk(1, OP_I, 0, 6, 0, 0, 0, 0, 0, 0, 0, 'h1E, 4, 0));
`ifdef ISSUE_SCOREBOARD_BYPASS_EN
    vecs.push_back(mk(1, OP_I, 0, 6, 0, 1, 2, 1, 1, 6, 1, 'h5A, 4, 0));
    vecs.push_back(mk(0, OP_I, 0, 6, 0, 0, 0, 0, 0, 0, 0, 'h5A, 4, 0));
`else
    vecs.push_back(mk(1, OP_I, 0, 6, 0, 1, 2, 0, 0, 0, 0, 'h1A, 3, 0));
    vecs.push_back(mk(1, OP_I, 0, 6, 0, 0, 0, 1, 1, 6, 1, 'h5A, 4, 0));
`endif
    // Scenario 3: simultaneous fire and writeback at inflight=2
    vecs.push_back(mk(0, OP_J, 0, 0, 0, 1, 1, 1, 0, 0, 0, 'h58, 3, 0));
    vecs.push_back(mk(0, OP_J, 0, 0, 0, 1, 4, 1, 0, 0, 0, 'h48, 2, 0));
    vecs.push_back(mk(1, OP_I, 0, 7, 0, 1, 3, 1, 1, 7, 1, 'hC0, 2, 0));
    // J ignores a busy rs and writes nothing
    vecs.push_back(mk(1, OP_J, 6, 7, 0, 0, 0, 1, 1, 0, 0, 'hC0, 2, 0));
    // Scenario 4: wb to r0 ignored, spurious wb sets sticky error
    vecs.push_back(mk(0, OP_J, 0, 0, 0, 1, 0, 1, 0, 0, 0, 'hC0, 2, 0));
    vecs.push_back(mk(0, OP_J, 0, 0, 0, 1, 9, 1, 0, 0, 0, 'hC0, 2, 1));
    vecs.push_back(mk(0, OP_J, 0, 0, 0, 0, 0, 1, 0, 0, 0, 'hC0, 2, 1));
    // R-type rt hazard; I-type with rt=0 issues without a write
    vecs.push_back(mk(1, OP_R, 0, 7, 10, 0, 0, 0, 0, 0, 0, 'hC0, 2, 1));
    vecs.push_back(mk(1, OP_I, 0, 0, 0, 0, 0, 1, 1, 0, 0, 'hC0, 2, 1));
`ifdef ISSUE_SCOREBOARD_BYPASS_EN
    vecs.push_back(mk(1, OP_I, 0, 6, 0, 1, 6, 1, 1, 6, 1, 'hC0, 2, 1));
`else
    vecs.push_back(mk(1, OP_I, 0, 6, 0, 1, 6, 0, 0, 0, 0, 'h80, 1, 1));
`endif

    tick();
    tick();
    rst = 1'b0;
    chk("rst_ready", 32'(id_ready), 1);
    chk("rst_iv", 32'(issue_valid), 0);
    chk("rst_ird", 32'(issue_rd), 0);
    chk("rst_iwen", 32'(issue_wen), 0);
    chk("rst_busy", busy_mask, 0);
    chk("rst_inf", 32'(inflight), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_err", 32'(sb_error), 0);

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].wbv, vecs[i].wbrd);
      #1;
      chk($sformatf("v%0d_ready", i), 32'(id_ready), 32'(vecs[i].e_rdy));
      tick();
      chk($sformatf("v%0d_iv", i), 32'(issue_valid), 32'(vecs[i].e_iv));
      if (vecs[i].e_iv) begin
        chk($sformatf("v%0d_ird", i), 32'(issue_rd), 32'(vecs[i].e_ird));
        chk($sformatf("v%0d_iwen", i), 32'(issue_wen), 32'(vecs[i].e_iwen));
      end
      chk($sformatf("v%0d_busy", i), busy_mask, vecs[i].e_busy);
      chk($sformatf("v%0d_inf", i), 32'(inflight), 32'(vecs[i].e_inf));
      chk($sformatf("v%0d_err", i), 32'(sb_error), 32'(vecs[i].e_err));
      chk($sformatf("v%0d_halted", i), 32'(halted), 0);
    end

    // HALT drain with two writes in flight
    do_rst();
    drive(1, OP_I, 0, 1, 0, 0, 0); tick();
    drive(1, OP_I, 0, 2, 0, 0, 0); tick();
    chk("hd_inf2", 32'(inflight), 2);
    drive(1, OP_H, 0, 0, 0, 0, 0); #1;
    chk("hd_halt_ready", 32'(id_ready), 1);
    tick();
    chk("hd_halt_iv", 32'(issue_valid), 1);
    chk("hd_halt_iwen", 32'(issue_wen), 0);
    chk("hd_halt_inf", 32'(inflight), 2);
    drive(1, OP_I, 0, 3, 0, 0, 0); #1;
    chk("hd_drain_ready0", 32'(id_ready), 0);
    tick();
    chk("hd_drain_iv0", 32'(issue_valid), 0);
    drive(1, OP_I, 0, 3, 0, 1, 1); #1;
    chk("hd_drain_ready1", 32'(id_ready), 0);
    tick();
    chk("hd_wb1_inf", 32'(inflight), 1);
    chk("hd_wb1_halted", 32'(halted), 0);
    drive(1, OP_I, 0, 3, 0, 1, 2); tick();
    chk("hd_wb2_halted", 32'(halted), 1);
    chk("hd_wb2_inf", 32'(inflight), 0);
    chk("hd_wb2_iv", 32'(issue_valid), 0);
    drive(1, OP_I, 0, 3, 0, 0, 0); #1;
    chk("hd_halted_ready", 32'(id_ready), 0);
    tick();
    chk("hd_halted_iv", 32'(issue_valid), 0);
    chk("hd_halted_sticky", 32'(halted), 1);

    // HALT with nothing in flight drains in one cycle
    do_rst();
    chk("he_rst_halted", 32'(halted), 0);
    drive(1, OP_H, 0, 0, 0, 0, 0); tick();
    chk("he_drain_halted", 32'(halted), 0);
    drive(0, OP_J, 0, 0, 0, 0, 0); tick();
    chk("he_halted", 32'(halted), 1);

    // Reset in the middle of a drain
    do_rst();
    drive(1, OP_I, 0, 5, 0, 0, 0); tick();
    drive(1, OP_H, 0, 0, 0, 0, 0); tick();
    drive(1, OP_I, 0, 3, 0, 0, 0); #1;
    chk("rd_drain_ready", 32'(id_ready), 0);
    chk("rd_drain_busy", busy_mask, 'h20);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rd_busy", busy_mask, 0);
    chk("rd_inf", 32'(inflight), 0);
    chk("rd_halted", 32'(halted), 0);
    chk("rd_iv", 32'(issue_valid), 0);
    chk("rd_ready", 32'(id_ready), 1);
    tick();
    chk("rd_issue_iv", 32'(issue_valid), 1);
    chk("rd_issue_rd", 32'(issue_rd), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
